// File: rtl/ghost_collision_if.sv
// Signal bundle between the VGA/sprite side and ghost_collision_ctrl.
// The master drives pixel position, sprite flags and positions; the slave returns game state.
interface ghost_collision_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       yoshi_on;
  logic       ghost_crazy_on;
  logic [9:0] y_x;
  logic [9:0] y_y;
  logic [9:0] g_c_x;
  logic [9:0] g_c_y;
  logic       restart;
  logic [3:0] lives;
  logic       hit_pulse;
  logic       ghost_respawn;
  logic       yoshi_blank;
  logic       game_over;

  modport master (
    output x, y, yoshi_on, ghost_crazy_on, y_x, y_y, g_c_x, g_c_y, restart,
    input  lives, hit_pulse, ghost_respawn, yoshi_blank, game_over
  );

  modport slave (
    input  x, y, yoshi_on, ghost_crazy_on, y_x, y_y, g_c_x, g_c_y, restart,
    output lives, hit_pulse, ghost_respawn, yoshi_blank, game_over
  );
endinterface

// File: rtl/ghost_collision_ctrl.sv
// Per-frame ghost/Yoshi collision, life counter, invulnerability blink and game-over control.
// Define GHOST_COLLISION_BOX_EN to also detect hits by 16x16 bounding-box overlap.
module ghost_collision_ctrl #(
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_BIT     = 3,
  parameter int MAX_Y         = 480
) (
  input  logic clk,
  input  logic reset,
  ghost_collision_if.slave bus
);

  typedef enum logic [1:0] {
    ST_PLAY   = 2'd0,
    ST_INVULN = 2'd1,
    ST_OVER   = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] lives_q, lives_d;
  logic [7:0] inv_cnt_q, inv_cnt_d;
  logic       hit_latch_q, hit_latch_d;
  logic       tick_prev_q, tick_prev_d;
  logic       hit_pulse_q, hit_pulse_d;
  logic       respawn_q, respawn_d;

  logic tick_cmp;
  logic frame_tick;
  logic hit_set;
  logic hit_now;
  logic box_hit;

  assign tick_cmp   = (bus.x == 10'd0) && (bus.y == 10'(MAX_Y));
  // Edge detect: the compare stays true for several clocks per pixel.
  assign frame_tick = tick_cmp && !tick_prev_q;
  assign tick_prev_d = tick_cmp;

`ifdef GHOST_COLLISION_BOX_EN
  logic [10:0] box_dx;
  logic [10:0] box_dy;

  always_comb begin
    box_dx = (bus.g_c_x >= bus.y_x) ? ({1'b0, bus.g_c_x} - {1'b0, bus.y_x})
                                    : ({1'b0, bus.y_x} - {1'b0, bus.g_c_x});
    box_dy = (bus.g_c_y >= bus.y_y) ? ({1'b0, bus.g_c_y} - {1'b0, bus.y_y})
                                    : ({1'b0, bus.y_y} - {1'b0, bus.g_c_y});
    box_hit = (box_dx < 11'd16) && (box_dy < 11'd16);
  end
`else
  logic unused_box_inputs;
  assign unused_box_inputs = ^{bus.g_c_x, bus.g_c_y, bus.y_x, bus.y_y};
  assign box_hit = 1'b0;
`endif

  assign hit_set = (bus.yoshi_on && bus.ghost_crazy_on) || box_hit;
  // A hit in the tick cycle itself still belongs to the frame that is closing.
  assign hit_now = hit_latch_q || hit_set;

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    inv_cnt_d   = inv_cnt_q;
    hit_pulse_d = 1'b0;
    respawn_d   = 1'b0;
    hit_latch_d = frame_tick ? 1'b0 : (hit_latch_q || hit_set);

    case (state_q)
      ST_PLAY: begin
        if (frame_tick && hit_now) begin
          hit_pulse_d = 1'b1;
          respawn_d   = 1'b1;
          if (lives_q <= 4'd1) begin
            lives_d = 4'd0;
            state_d = ST_OVER;
          end else begin
            lives_d   = lives_q - 4'd1;
            inv_cnt_d = 8'(INVULN_FRAMES);
            state_d   = ST_INVULN;
          end
        end
      end
      ST_INVULN: begin
        if (frame_tick) begin
          if (inv_cnt_q <= 8'd1) begin
            inv_cnt_d = 8'd0;
            state_d   = ST_PLAY;
          end else begin
            inv_cnt_d = inv_cnt_q - 8'd1;
          end
        end
      end
      ST_OVER: begin
        lives_d = 4'd0;
        // Restart beats a coincident frame tick and drops any pending hit.
        if (bus.restart) begin
          state_d     = ST_PLAY;
          lives_d     = 4'(LIVES);
          inv_cnt_d   = 8'd0;
          respawn_d   = 1'b1;
          hit_latch_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_PLAY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_PLAY;
      lives_q     <= 4'(LIVES);
      inv_cnt_q   <= 8'd0;
      hit_latch_q <= 1'b0;
      tick_prev_q <= 1'b1;
      hit_pulse_q <= 1'b0;
      respawn_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      inv_cnt_q   <= inv_cnt_d;
      hit_latch_q <= hit_latch_d;
      tick_prev_q <= tick_prev_d;
      hit_pulse_q <= hit_pulse_d;
      respawn_q   <= respawn_d;
    end
  end

  assign bus.lives         = lives_q;
  assign bus.hit_pulse     = hit_pulse_q;
  assign bus.ghost_respawn = respawn_q;
  assign bus.game_over     = (state_q == ST_OVER);
  assign bus.yoshi_blank   = (state_q == ST_INVULN) && inv_cnt_q[BLINK_BIT];

endmodule

// File: tb/tb_ghost_collision_ctrl.sv
// Scoreboard bench for ghost_collision_ctrl: a frame-level model pushes expectations per tick,
// popped and compared once the registered outputs appear.
module tb_ghost_collision_ctrl;
  localparam int LIVES = 3;
  localparam int INV   = 20;
  localparam int BB    = 3;
  localparam int MAX_Y = 480;
`ifdef GHOST_COLLISION_BOX_EN
  localparam bit BOX_EN = 1'b1;
`else
  localparam bit BOX_EN = 1'b0;
`endif

  typedef struct {
    logic       hp;
    logic       rp;
    logic [3:0] lives;
    logic       over;
    logic       blank;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ghost_collision_if bus();

  ghost_collision_ctrl #(
    .LIVES(LIVES), .INVULN_FRAMES(INV), .BLINK_BIT(BB), .MAX_Y(MAX_Y)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   m_st;
  int   m_lives;
  int   m_inv;
  bit   m_pending;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_state(inout exp_t e);
    e.lives = 4'(m_lives);
    e.over  = (m_st == 2);
    e.blank = (m_st == 1) ? 1'(m_inv >> BB) : 1'b0;
  endtask

  task automatic model_tick(input bit h, input bit rs, output exp_t e);
    e.hp = 1'b0;
    e.rp = 1'b0;
    case (m_st)
      0: if (h) begin
        e.hp = 1'b1;
        e.rp = 1'b1;
        if (m_lives == 1) begin
          m_lives = 0;
          m_st    = 2;
        end else begin
          m_lives--;
          m_inv = INV;
          m_st  = 1;
        end
      end
      1: begin
        m_inv--;
        if (m_inv == 0) m_st = 0;
      end
      default: if (rs) begin
        m_st    = 0;
        m_lives = LIVES;
        e.rp    = 1'b1;
      end
    endcase
    fill_state(e);
  endtask

  task automatic compare(input string tag);
    exp_t o;
    o = sb_q.pop_front();
    chk({tag, "_hit"},   bus.hit_pulse,     o.hp);
    chk({tag, "_resp"},  bus.ghost_respawn, o.rp);
    chk({tag, "_lives"}, bus.lives,         o.lives);
    chk({tag, "_over"},  bus.game_over,     o.over);
    chk({tag, "_blank"}, bus.yoshi_blank,   o.blank);
  endtask

  // One short frame: body pixels, then the tick cycle, then one hold cycle at the tick position.
  task automatic frame(input bit ovb, input bit ovt, input bit rs, input string tag);
    exp_t e;
    bus.x = 10'd5; bus.y = 10'd10;
    bus.yoshi_on = ovb; bus.ghost_crazy_on = ovb; bus.restart = 1'b0;
    repeat (3) step();
    bus.x = 10'd0; bus.y = 10'(MAX_Y);
    bus.yoshi_on = ovt; bus.ghost_crazy_on = ovt; bus.restart = rs;
    model_tick(m_pending | ovb | ovt, rs, e);
    m_pending = 1'b0;
    sb_q.push_back(e);
    step();
    bus.yoshi_on = 1'b0; bus.ghost_crazy_on = 1'b0; bus.restart = 1'b0;
    compare(tag);
    step();
    chk({tag, "_hit_end"},  bus.hit_pulse,     1'b0);
    chk({tag, "_resp_end"}, bus.ghost_respawn, 1'b0);
  endtask

  task automatic do_restart(input string tag);
    exp_t e;
    e.hp = 1'b0;
    e.rp = 1'b0;
    if (m_st == 2) begin
      m_st      = 0;
      m_lives   = LIVES;
      m_pending = 1'b0;
      e.rp      = 1'b1;
    end
    fill_state(e);
    sb_q.push_back(e);
    bus.x = 10'd5; bus.y = 10'd10; bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    compare(tag);
    step();
    chk({tag, "_resp_end"}, bus.ghost_respawn, 1'b0);
  endtask

  task automatic far_apart();
    bus.g_c_x = 10'd300; bus.g_c_y = 10'd300;
    bus.y_x   = 10'd10;  bus.y_y   = 10'd10;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1);
  end

  initial begin
    m_st = 0; m_lives = LIVES; m_inv = 0; m_pending = 1'b0;
    far_apart();
    reset = 1'b0;
    bus.x = 10'd0; bus.y = 10'(MAX_Y);
    bus.yoshi_on = 1'b0; bus.ghost_crazy_on = 1'b0; bus.restart = 1'b0;
    repeat (2) step();
    chk("rst_lives", bus.lives,         4'(LIVES));
    chk("rst_over",  bus.game_over,     1'b0);
    chk("rst_blank", bus.yoshi_blank,   1'b0);
    chk("rst_hit",   bus.hit_pulse,     1'b0);
    chk("rst_resp",  bus.ghost_respawn, 1'b0);

    // Tick position held through reset release: no tick, so the overlap stays latched for the next frame.
    reset = 1'b1;
    bus.yoshi_on = 1'b1; bus.ghost_crazy_on = 1'b1;
    step();
    chk("post_rst_hit0", bus.hit_pulse, 1'b0);
    bus.yoshi_on = 1'b0; bus.ghost_crazy_on = 1'b0;
    step();
    chk("post_rst_hit1", bus.hit_pulse, 1'b0);
    chk("post_rst_lives", bus.lives, 4'(LIVES));
    m_pending = 1'b1;

    frame(1'b0, 1'b0, 1'b0, "first_hit");
    for (int i = 0; i < INV; i++) frame(1'b1, 1'b1, 1'b0, "inv_window");
    frame(1'b1, 1'b1, 1'b0, "rehit");
    do_restart("restart_in_inv");
    for (int i = 0; i < INV; i++) frame(1'b0, 1'b0, 1'b0, "inv_quiet");
    frame(1'b0, 1'b1, 1'b0, "fatal_tick_hit");
    frame(1'b1, 1'b1, 1'b0, "over_hit1");
    frame(1'b1, 1'b1, 1'b0, "over_hit2");
    do_restart("restart_over");

    frame(1'b0, 1'b1, 1'b0, "coinc_hit");
    for (int i = 0; i < INV; i++) frame(1'b0, 1'b0, 1'b0, "coinc_inv");
    frame(1'b0, 1'b0, 1'b0, "coinc_next");

    bus.g_c_x = 10'd100; bus.g_c_y = 10'd100;
    bus.y_x   = 10'd110; bus.y_y   = 10'd105;
    m_pending = BOX_EN;
    frame(1'b0, 1'b0, 1'b0, "box");
    far_apart();

    for (int k = 0; k < 8 && m_st != 2; k++) begin
      frame(1'b0, 1'b1, 1'b0, "drain_hit");
      for (int i = 0; i < INV && m_st == 1; i++) frame(1'b0, 1'b0, 1'b0, "drain_inv");
    end
    frame(1'b1, 1'b1, 1'b1, "restart_on_tick");
    frame(1'b0, 1'b0, 1'b0, "after_restart_tick");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
